// File: rtl/lsu_mem_ctrl.sv
// Load/store front end for word-addressed dmem: B/H/W loads, W stores, B/H stores via read-modify-write.
// resp_valid 2 cycles after accept (3 for sub-word store); req_ready only in IDLE. LSU_MISALIGN_TRAP_EN: misaligned H/W -> resp_err.
module lsu_mem_ctrl #(
  parameter int          WORD_AW     = 27,
  parameter logic [31:0] RESET_RDATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_rw
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  state_t             r_state, w_next;
  logic               r_we, r_err;
  logic [2:0]         r_funct3;
  logic [WORD_AW+1:0] r_addr;
  logic [31:0]        r_wdata, r_old, r_rdata;

  logic        w_accept, w_ill, w_oor, w_err;
  logic [31:0] w_addr_acc, w_mask, w_merge, w_lane, w_ext;
  logic [4:0]  w_sh;

  assign w_accept = req_valid && (r_state == S_IDLE);

  always_comb begin
    w_ill = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) || (req_funct3[2] && req_we);
    w_oor = |req_addr[31:WORD_AW+2];
`ifdef LSU_MISALIGN_TRAP_EN
    w_err      = w_ill || w_oor ||
                 ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (|req_addr[1:0]));
    w_addr_acc = req_addr;
`else
    w_err      = w_ill || w_oor;
    w_addr_acc = req_addr;
    if (req_funct3[1:0] == 2'b01) w_addr_acc[0]   = 1'b0;
    if (req_funct3[1:0] == 2'b10) w_addr_acc[1:0] = 2'b00;
`endif
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_err)                        w_next = S_DONE;
          else if (!req_we)                 w_next = S_RD;
          else if (req_funct3[1:0] == 2'b10) w_next = S_WR;
          else                              w_next = S_RD;
        end
      end
      S_RD:    w_next = r_we ? S_WR : S_DONE;
      S_WR:    w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // Lane shift is shared by load extraction and store merge; addr is already aligned for H/W.
  always_comb begin
    w_sh = {r_addr[1:0], 3'b000};
    case (r_funct3[1:0])
      2'b00:   w_mask = 32'h0000_00FF;
      2'b01:   w_mask = 32'h0000_FFFF;
      default: w_mask = 32'hFFFF_FFFF;
    endcase
    w_merge = (r_old & ~(w_mask << w_sh)) | ((r_wdata & w_mask) << w_sh);
    w_lane  = mem_rdata >> w_sh;
    case (r_funct3)
      3'b000:  w_ext = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_ext = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_ext = {24'h0, w_lane[7:0]};
      3'b101:  w_ext = {16'h0, w_lane[15:0]};
      default: w_ext = w_lane;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= '0;
      r_wdata  <= 32'h0;
      r_old    <= 32'h0;
      r_rdata  <= RESET_RDATA;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we     <= req_we;
        r_funct3 <= req_funct3;
        r_addr   <= w_addr_acc[WORD_AW+1:0];
        r_wdata  <= req_wdata;
        r_err    <= w_err;
      end
      if (r_state == S_RD) r_old <= mem_rdata;
      // Only loads reach DONE from RD; stores and errors report RESET_RDATA.
      if (w_next == S_DONE) r_rdata <= (r_state == S_RD) ? w_ext : RESET_RDATA;
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_DONE);
  assign resp_err   = r_err && (r_state == S_DONE);
  assign resp_rdata = r_rdata;
  assign mem_rw     = (r_state != S_WR);
  assign mem_addr   = {{(32-WORD_AW){1'b0}}, r_addr[WORD_AW+1:2]};
  assign mem_wdata  = (r_state == S_WR) ? w_merge : 32'h0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a 256-word behavioural dmem.
module tb_lsu_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_rw;

  logic [31:0] mem [0:255];
  int          wr_cnt = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  lsu_mem_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rw(mem_rw)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rw === 1'b0) mem[mem_addr[7:0]] <= mem_wdata;
  assign mem_rdata = mem[mem_addr[7:0]];

  always @(negedge clk) if (mem_rw === 1'b0) wr_cnt <= wr_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // lat counts posedges from the accept edge (inclusive) to the edge that raises resp_valid.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic err);
    for (int i = 0; i < 8 && !req_ready; i++) begin
      @(posedge clk); #1;
    end
    chk("req_ready", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    lat = 99; rd = 32'hX; err = 1'bX;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (resp_valid) begin
        lat = i; rd = resp_rdata; err = resp_err;
        break;
      end
    end
  endtask

  int          lat, w0;
  logic [31:0] rd;
  logic        err;

  initial begin
    #3;
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_rw", {31'h0, mem_rw}, 32'h1);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Preload via word stores
    do_req(1'b1, 3'b010, 32'h40, 32'h8899_AABB, lat, rd, err);
    do_req(1'b1, 3'b010, 32'h04, 32'hCAFE_F00D, lat, rd, err);
    do_req(1'b1, 3'b010, 32'h30, 32'h5555_AAAA, lat, rd, err);

    do_req(1'b0, 3'b000, 32'h43, 32'h0, lat, rd, err);
    chk("lb_0x43_rdata", rd, 32'hFFFF_FF88);
    chk("lb_0x43_err", {31'h0, err}, 32'h0);
    chk("lb_0x43_lat", lat, 2);
    do_req(1'b0, 3'b001, 32'h42, 32'h0, lat, rd, err);
    chk("lh_0x42_rdata", rd, 32'hFFFF_8899);
    do_req(1'b0, 3'b000, 32'h40, 32'h0, lat, rd, err);
    chk("lb_0x40_rdata", rd, 32'hFFFF_FFBB);
    do_req(1'b0, 3'b100, 32'h43, 32'h0, lat, rd, err);
    chk("lbu_0x43_rdata", rd, 32'h0000_0088);

    w0 = wr_cnt;
    do_req(1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF, lat, rd, err);
    chk("sw_0x20_lat", lat, 2);
    chk("sw_0x20_rdata", rd, 32'h0);
    chk("sw_0x20_err", {31'h0, err}, 32'h0);
    chk("sw_0x20_wr_cycles", wr_cnt - w0, 1);
    chk("sw_0x20_mem", mem[8'h08], 32'hDEAD_BEEF);
    do_req(1'b0, 3'b010, 32'h20, 32'h0, lat, rd, err);
    chk("lw_0x20_rdata", rd, 32'hDEAD_BEEF);
    chk("lw_0x20_lat", lat, 2);

    do_req(1'b1, 3'b010, 32'h20, 32'h1122_3344, lat, rd, err);
    w0 = wr_cnt;
    do_req(1'b1, 3'b000, 32'h21, 32'h0000_00AA, lat, rd, err);
    chk("sb_0x21_lat", lat, 3);
    chk("sb_0x21_wr_cycles", wr_cnt - w0, 1);
    chk("sb_0x21_mem", mem[8'h08], 32'h1122_AA44);
    do_req(1'b0, 3'b101, 32'h22, 32'h0, lat, rd, err);
    chk("lhu_0x22_rdata", rd, 32'h0000_1122);
    do_req(1'b1, 3'b001, 32'h22, 32'hFFFF_5A6B, lat, rd, err);
    chk("sh_0x22_mem", mem[8'h08], 32'h5A6B_AA44);

    w0 = wr_cnt;
    do_req(1'b0, 3'b010, 32'h06, 32'h0, lat, rd, err);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lw_0x06_err", {31'h0, err}, 32'h1);
    chk("lw_0x06_rdata", rd, 32'h0);
    chk("lw_0x06_lat", lat, 1);
`else
    chk("lw_0x06_err", {31'h0, err}, 32'h0);
    chk("lw_0x06_rdata", rd, 32'hCAFE_F00D);
    chk("lw_0x06_lat", lat, 2);
`endif
    chk("lw_0x06_no_write", wr_cnt - w0, 0);

    do_req(1'b0, 3'b010, 32'h8000_0000, 32'h0, lat, rd, err);
    chk("oor_err", {31'h0, err}, 32'h1);
    chk("oor_lat", lat, 1);
    w0 = wr_cnt;
    do_req(1'b1, 3'b100, 32'h30, 32'h0000_0011, lat, rd, err);
    chk("sbu_err", {31'h0, err}, 32'h1);
    chk("sbu_rdata", rd, 32'h0);
    chk("sbu_no_write", wr_cnt - w0, 0);
    chk("sbu_mem", mem[8'h0C], 32'h5555_AAAA);
    do_req(1'b0, 3'b011, 32'h30, 32'h0, lat, rd, err);
    chk("f3_011_err", {31'h0, err}, 32'h1);

    // Reset in the WR cycle of an SH must leave the target word untouched
    do_req(1'b1, 3'b010, 32'h80, 32'hAABB_CCDD, lat, rd, err);
    for (int i = 0; i < 8 && !req_ready; i++) begin
      @(posedge clk); #1;
    end
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h82; req_wdata = 32'h0000_1234;
    @(posedge clk); #1 req_valid = 1'b0;
    chk("sh_rd_mem_rw", {31'h0, mem_rw}, 32'h1);
    @(posedge clk); #1;
    chk("sh_wr_mem_rw", {31'h0, mem_rw}, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("sh_rst_mem_rw", {31'h0, mem_rw}, 32'h1);
    chk("sh_rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("sh_rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("sh_rst_mem", mem[8'h20], 32'hAABB_CCDD);
    chk("sh_rst_no_resp", {31'h0, resp_valid}, 32'h0);
    do_req(1'b0, 3'b010, 32'h80, 32'h0, lat, rd, err);
    chk("sh_rst_lw", rd, 32'hAABB_CCDD);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store controller directly upstream of the word-addressed data memory (dmem) in the RISC-V datapath.
- Accepts byte, half and word load/store requests from the execute stage via a valid/ready handshake.
- Translates each request into dmem word accesses; sub-word stores use read-modify-write.
- Returns sign- or zero-extended load data with a one-cycle response pulse.

Parameters:
- WORD_AW, 27, word-index width driven to dmem; byte addresses must satisfy req_addr[31:WORD_AW+2]==0.
- RESET_RDATA, 32'h0000_0000, value of resp_rdata after reset and for store/error responses.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; high only in IDLE.
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; RESET_RDATA for stores and errors.
- resp_err  out  1  valid with resp_valid: misaligned, out-of-range or illegal funct3.
- mem_addr  out  32  word index to dmem (zero-extended byte_addr>>2).
- mem_wdata  out  32  word written to dmem.
- mem_rdata  in  32  dmem read data (combinational).
- mem_rw  out  1  dmem control: 0=write on next posedge, 1=read.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=RESET_RDATA, mem_rw=1, mem_addr=0, mem_wdata=0. All captured request registers clear.
- mem_rw=0 only in state WR, and only ever for one cycle per request. All other states drive mem_rw=1, so no spurious writes occur.
- Accept on the posedge where req_valid && req_ready. The block latches we, funct3, addr and wdata. Inputs are ignored outside IDLE.
- Error check at accept:
  - misaligned: H with addr[0]!=0, or W with addr[1:0]!=0;
  - out-of-range: upper address bits nonzero;
  - illegal funct3: 011, 11x, or BU/HU with we=1.
- On error: IDLE->DONE, resp_err=1, no dmem access.
- States: IDLE, RD, WR, DONE.
  - Load: IDLE->RD->DONE. In RD, mem_addr=word index and mem_rw=1; mem_rdata is captured at the end of RD. Latency: resp_valid 2 cycles after the accept edge.
  - SW: IDLE->WR->DONE. mem_wdata=req_wdata. The write completes on the WR->DONE edge.
  - SB/SH: IDLE->RD->WR->DONE. RD captures the old word. WR writes the merged word: the byte lane selected by addr[1:0] (byte) or halfword lane addr[1] (half) is replaced from the low bits of wdata. Latency: 3 cycles.
  - DONE: resp_valid=1 for exactly one cycle, then IDLE with req_ready=1. There is no back-to-back accept during DONE.
- Load extraction: the lane is selected by addr[1:0]. B/H are sign-extended from bit 7/15; BU/HU are zero-extended. resp_rdata holds its value until the next DONE.
- Reset asserted mid-RMW (RD or WR): return immediately to IDLE. No write is issued after reset deasserts. Memory contents may hold the pre-request word, never a partial merge.
- req_valid deasserting after accept has no effect; the request always completes.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: misaligned H/W requests produce resp_err=1 without memory access, as above.
- Undefined: misalignment is not an error. Address low bits are forced aligned (H clears bit0, W clears bits[1:0]) and the access proceeds normally. Out-of-range and illegal funct3 still set resp_err.

Test Plan:
- Preload word 0x10 = 32'h8899_AABB; LB addr 0x43 -> resp_rdata 32'hFFFF_FF88, resp_err=0, resp_valid 2 cycles after accept.
- SW addr 0x20 data 32'hDEAD_BEEF, then LW 0x20 -> mem_rw low exactly 1 cycle, rdata 32'hDEAD_BEEF.
- Word 0x08 = 32'h1122_3344; SB addr 0x21 data 32'h0000_00AA -> memory word 32'h1122_AA44, resp_valid 3 cycles after accept; LHU 0x22 -> 32'h0000_1122.
- LW addr 0x06 with macro -> resp_err=1 and mem_rw never 0; without macro -> reads word 0x01.
- Request with addr 32'h8000_0000 -> resp_err=1; funct3=100 with we=1 -> resp_err=1, no write.
- Assert rst_n=0 during WR of an SH -> state IDLE, mem_rw=1, target word unchanged after release.
